// File: rtl/axis_skid_buffer.sv
// AXI-Stream skid buffer: axis_in_ready comes straight from a flop, so the
// consumer's ready never reaches the producer combinationally.
module axis_skid_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 1,
    parameter int DEST_WIDTH      = 1,
    parameter bit REGISTER_OUTPUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] axis_in_data,
    input  logic [USER_WIDTH-1:0] axis_in_user,
    input  logic [DEST_WIDTH-1:0] axis_in_dest,
    input  logic                  axis_in_tlast,
    input  logic                  axis_in_valid,
    output logic                  axis_in_ready,

    output logic [DATA_WIDTH-1:0] axis_out_data,
    output logic [USER_WIDTH-1:0] axis_out_user,
    output logic [DEST_WIDTH-1:0] axis_out_dest,
    output logic                  axis_out_tlast,
    output logic                  axis_out_valid,
    input  logic                  axis_out_ready
);

    localparam int PW = DATA_WIDTH + USER_WIDTH + DEST_WIDTH + 1;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] out_pay;
    logic [PW-1:0] skid_pay_q, skid_pay_d;
    logic          skid_valid_q, skid_valid_d;
    logic          out_valid;
    logic          in_xfer;

    // The whole beat moves as one vector so sidebands can never skew from data.
    assign in_pay        = {axis_in_tlast, axis_in_dest, axis_in_user, axis_in_data};
    assign axis_in_ready = !skid_valid_q && !rst;
    assign in_xfer       = axis_in_valid && axis_in_ready;

    generate
        if (REGISTER_OUTPUT) begin : g_reg_out
            logic          out_valid_q, out_valid_d;
            logic [PW-1:0] out_pay_q, out_pay_d;
            logic          load_out;

            always_comb begin
                load_out     = !out_valid_q || axis_out_ready;
                out_valid_d  = out_valid_q;
                out_pay_d    = out_pay_q;
                skid_valid_d = skid_valid_q;
                skid_pay_d   = skid_pay_q;
                if (load_out) begin
                    // When the skid beat moves up, ready is already low, so in_xfer is 0.
                    out_valid_d  = skid_valid_q || in_xfer;
                    out_pay_d    = skid_valid_q ? skid_pay_q : in_pay;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    skid_valid_d = 1'b1;
                    skid_pay_d   = in_pay;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_pay_q   <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_pay_q   <= out_pay_d;
                end
            end

            assign out_valid = out_valid_q;
            assign out_pay   = out_pay_q;
        end else begin : g_comb_out
            always_comb begin
                skid_valid_d = skid_valid_q;
                skid_pay_d   = skid_pay_q;
                if (in_xfer && !axis_out_ready) begin
                    skid_valid_d = 1'b1;
                    skid_pay_d   = in_pay;
                end else if (skid_valid_q && axis_out_ready) begin
                    skid_valid_d = 1'b0;
                end
            end

            assign out_valid = skid_valid_q || axis_in_valid;
            assign out_pay   = skid_valid_q ? skid_pay_q : in_pay;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
        end
    end

    // Masking with rst keeps valid low for the whole reset, including its first cycle.
    assign axis_out_valid = out_valid && !rst;
    assign {axis_out_tlast, axis_out_dest, axis_out_user, axis_out_data} = out_pay;

endmodule

// File: tb/tb_axis_skid_buffer.sv
// Directed bench for axis_skid_buffer: registered-output instance with a
// scoreboard monitor, plus a combinational-output instance.
module tb_axis_skid_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] in_data;
    logic        in_user, in_dest, in_last, in_valid, in_ready;
    logic [31:0] out_data;
    logic        out_user, out_dest, out_last, out_valid, out_ready;

    logic [31:0] i0_data;
    logic        i0_user, i0_dest, i0_last, i0_valid, i0_ready;
    logic [31:0] o0_data;
    logic        o0_user, o0_dest, o0_last, o0_valid, o0_ready;

    int total = 0;
    int bad   = 0;
    int in_cnt = 0, out_cnt = 0;
    logic [34:0] sbq[$];
    logic [34:0] exp_b;

    always #5 clk = ~clk;

    axis_skid_buffer #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .REGISTER_OUTPUT(1)) dut (
        .clk(clk), .rst(rst),
        .axis_in_data(in_data), .axis_in_user(in_user), .axis_in_dest(in_dest),
        .axis_in_tlast(in_last), .axis_in_valid(in_valid), .axis_in_ready(in_ready),
        .axis_out_data(out_data), .axis_out_user(out_user), .axis_out_dest(out_dest),
        .axis_out_tlast(out_last), .axis_out_valid(out_valid), .axis_out_ready(out_ready)
    );

    axis_skid_buffer #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .REGISTER_OUTPUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .axis_in_data(i0_data), .axis_in_user(i0_user), .axis_in_dest(i0_dest),
        .axis_in_tlast(i0_last), .axis_in_valid(i0_valid), .axis_in_ready(i0_ready),
        .axis_out_data(o0_data), .axis_out_user(o0_user), .axis_out_dest(o0_dest),
        .axis_out_tlast(o0_last), .axis_out_valid(o0_valid), .axis_out_ready(o0_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs only change just after posedge, so negedge sees what the next edge will take.
    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            sbq.push_back({in_last, in_dest, in_user, in_data});
            in_cnt++;
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (sbq.size() == 0) begin
                chk("sb_extra_beat", 64'd1, 64'd0);
            end else begin
                exp_b = sbq.pop_front();
                chk("sb_beat", {29'd0, out_last, out_dest, out_user, out_data}, {29'd0, exp_b});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int in0, out0, cyc;
        logic [31:0] idx;
        logic xfer;

        in_data = '0; in_user = 0; in_dest = 0; in_last = 0; in_valid = 0; out_ready = 0;
        i0_data = '0; i0_user = 0; i0_dest = 0; i0_last = 0; i0_valid = 0; o0_ready = 0;

        // reset held three cycles
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        tick();
        chk("rel_no_beats", out_cnt, 0);

        // single beat, no backpressure: latency one cycle, one cycle wide
        out_ready = 1; in_valid = 1; in_data = 32'hCAFECABE;
        tick();
        in_valid = 0;
        chk("nb_valid", out_valid, 1);
        chk("nb_data", out_data, 32'hCAFECABE);
        tick();
        chk("nb_valid_drop", out_valid, 0);
        chk("nb_in_cnt", in_cnt, 1);
        chk("nb_out_cnt", out_cnt, 1);

        // fill under backpressure, then drain one beat at a time
        in0 = in_cnt; out0 = out_cnt;
        out_ready = 0; in_valid = 1; in_data = 32'hDEADCAFE;
        #1;
        chk("bp_ready0", in_ready, 1);
        tick();
        chk("bp_ready1", in_ready, 1);
        chk("bp_out_valid", out_valid, 1);
        tick();
        chk("bp_full_ready", in_ready, 0);
        chk("bp_accepted2", in_cnt - in0, 2);
        tick();
        in_valid = 0;
        chk("bp_still_full", in_ready, 0);
        chk("bp_data_held", out_data, 32'hDEADCAFE);
        chk("bp_accepted_still2", in_cnt - in0, 2);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_pulse_one", out_cnt - out0, 1);
        chk("bp_skid_moved", out_valid, 1);
        chk("bp_skid_data", out_data, 32'hDEADCAFE);
        chk("bp_ready_back", in_ready, 1);
        tick();
        chk("bp_no_extra", out_cnt - out0, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_drained", out_valid, 0);
        chk("bp_in_total", in_cnt - in0, 2);
        chk("bp_out_total", out_cnt - out0, 2);

        // continuous flow: ready never drops, one beat per cycle
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            in_data = 32'h5000 + i;
            in_last = (i == 15);
            #1;
            chk("tp_in_ready", in_ready, 1);
            if (i > 0) chk("tp_out_data", out_data, 32'h5000 + i - 1);
            tick();
        end
        in_valid = 0; in_last = 0;
        tick();
        chk("tp_count_match", in_cnt, out_cnt);

        // random stall streaming, checked by the scoreboard
        in0 = in_cnt;
        idx = 0; cyc = 0;
        while (idx < 256 && cyc < 5000) begin
            if (!in_valid) in_valid = ($urandom_range(0, 3) != 0);
            in_data = idx;
            in_last = (idx[3:0] == 4'hF);
            in_user = idx[0];
            in_dest = idx[1];
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            xfer = in_valid && in_ready;
            tick();
            if (xfer) begin
                idx = idx + 1;
                in_valid = 0;
            end
            cyc++;
        end
        chk("st_timeout", idx, 256);
        in_valid = 0; in_last = 0; in_user = 0; in_dest = 0;
        out_ready = 1;
        repeat (4) tick();
        chk("st_in_count", in_cnt - in0, 256);
        chk("st_balance", out_cnt, in_cnt);
        chk("st_sb_empty", sbq.size(), 0);

        // reset with two beats stored
        out_ready = 0; in_valid = 1; in_data = 32'hAAAA0001;
        tick();
        in_data = 32'hAAAA0002;
        tick();
        in_valid = 0;
        chk("mr_full", in_ready, 0);
        rst = 1;
        #1;
        chk("mr_rst_valid", out_valid, 0);
        tick();
        sbq.delete();
        rst = 0;
        #1;
        chk("mr_after_valid", out_valid, 0);
        chk("mr_after_ready", in_ready, 1);
        in_valid = 1; in_data = 32'hBBBB0003; out_ready = 1;
        tick();
        in_valid = 0;
        chk("mr_first_valid", out_valid, 1);
        chk("mr_first_data", out_data, 32'hBBBB0003);
        tick();
        chk("mr_empty", out_valid, 0);
        out_ready = 0;

        // combinational output path
        i0_valid = 1; i0_data = 32'h12345678; o0_ready = 1;
        #1;
        chk("c0_same_cycle_valid", o0_valid, 1);
        chk("c0_same_cycle_data", o0_data, 32'h12345678);
        chk("c0_ready", i0_ready, 1);
        tick();
        i0_data = 32'h9ABCDEF0; o0_ready = 0;
        #1;
        chk("c0_pass_data", o0_data, 32'h9ABCDEF0);
        tick();
        i0_valid = 0; i0_data = '0;
        #1;
        chk("c0_skid_ready", i0_ready, 0);
        chk("c0_skid_valid", o0_valid, 1);
        chk("c0_skid_data", o0_data, 32'h9ABCDEF0);
        tick();
        chk("c0_hold_ready", i0_ready, 0);
        chk("c0_hold_data", o0_data, 32'h9ABCDEF0);
        o0_ready = 1;
        tick();
        chk("c0_drain_ready", i0_ready, 1);
        chk("c0_drain_valid", o0_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_skid_buffer.md
Name: axis_skid_buffer

Overview:
- Single-stage AXI-Stream skid buffer that breaks the combinational ready path between an upstream producer and a downstream consumer.
- Optionally also registers the forward path (valid, data and sidebands).
- Sits between any two axi_stream interfaces in the datapath.
- Sustains full throughput, with no loss, duplication or reordering of beats.

Parameters:
- DATA_WIDTH, 32: width of the data field.
- USER_WIDTH, 1: width of the user sideband.
- DEST_WIDTH, 1: width of the dest sideband.
- REGISTER_OUTPUT, 1:
  - 1: output valid, data and sidebands come from flops (latency 1, capacity 2 beats).
  - 0: combinational forward path (latency 0, capacity 1 skid beat).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- axis_in  axi_stream slave modport, carrying:
  - data [DATA_WIDTH-1:0]
  - user [USER_WIDTH-1:0]
  - dest [DEST_WIDTH-1:0]
  - tlast (1 bit)
  - valid (in), ready (out)
- axis_out  axi_stream master modport, same fields; valid (out), ready (in).

Behaviour:
- A transfer occurs on a rising edge when valid and ready are both 1 on the same interface. Data, user, dest and tlast travel together as one beat.
- Internal state:
  - skid register: skid_valid plus a copy of all payload fields.
  - When REGISTER_OUTPUT=1, an output register: out_valid plus payload.
- axis_in.ready = !skid_valid && !rst, driven straight from the flop (no combinational path from axis_out.ready).
- Reset (rst=1 at a clock edge):
  - skid_valid=0, out_valid=0; payload registers cleared to 0.
  - axis_in.ready=0 while rst is high; 1 on the first cycle after release.
  - axis_out.valid=0.
  - A beat in flight during reset is discarded.
- REGISTER_OUTPUT=1, per rising edge:
  - Output register can load when !out_valid || axis_out.ready:
    - out_valid <= skid_valid || (axis_in.valid && axis_in.ready).
    - Payload comes from skid if skid_valid, else from axis_in.
    - skid_valid <= 0.
  - Otherwise, if axis_in.valid && axis_in.ready: skid captures the axis_in payload and skid_valid <= 1.
  - When the output register takes the skid beat, a new input beat cannot be accepted that cycle (ready=0), so no beat is lost.
- REGISTER_OUTPUT=0:
  - axis_out.valid = skid_valid || axis_in.valid.
  - axis_out payload = skid payload if skid_valid, else axis_in payload.
  - If axis_in.valid && axis_in.ready && !axis_out.ready, capture into skid.
  - If skid_valid && axis_out.ready, clear skid.
- Ordering: beats leave in exactly the order accepted.
- Payload stability: while axis_out.valid && !axis_out.ready, the payload and valid are held stable.
- Throughput: with axis_out.ready held at 1, one beat per cycle indefinitely. axis_in.ready never drops in that case.
- Full: when skid_valid=1, axis_in.ready=0. It re-asserts the cycle after the skid drains.
- Simultaneous accept and drain are handled in one cycle without an idle cycle on the output.

Test Plan:
- Reset (REGISTER_OUTPUT=1 for all but the last case):
  - Stimulus: assert rst 3 cycles, then release.
  - Required: axis_out.valid=0 and axis_in.ready=0 during reset; ready=1 on the first cycle after; no output beats.
- No backpressure:
  - Stimulus: out.ready=1; a single in beat data=0xCAFECABE, valid for 1 cycle.
  - Required: out.valid=1 with 0xCAFECABE exactly 1 cycle later, for one cycle; 1 input transfer and 1 output transfer.
- Backpressure fill and drain:
  - Stimulus: out.ready=0; in.valid held 3 cycles with 0xDEADCAFE; then out.ready pulsed 1 cycle, then held 0.
  - Required:
    - After 2 accepted beats, in.ready=0 (2 beats stored).
    - The pulse delivers exactly one beat of 0xDEADCAFE.
    - The skid beat moves to the output and in.ready returns to 1 the next cycle.
    - A later out.ready delivers the second beat.
    - Input and output transfer counts both equal 2, with matching data.
- Streaming with random stall:
  - Stimulus: incrementing data 0..255 with tlast on every 16th beat; random in.valid and out.ready.
  - Required: output sequence identical (data, tlast, user, dest); no drops or duplicates; 1 beat/cycle whenever out.ready=1 continuously.
- Reset mid-operation:
  - Stimulus: fill 2 beats under backpressure, then assert rst 1 cycle.
  - Required: out.valid=0 the next cycle; stored beats discarded; next accepted beat is the first output after reset.
- REGISTER_OUTPUT=0:
  - Stimulus: out.ready=1, beat 0x12345678.
  - Required: out.valid and data appear in the same cycle. With out.ready=0, the second beat is held in skid and in.ready=0 until drained.
